// File: rtl/ssp_tx_fifo_if.sv
// Bus bundle between the APB write side, the SSP transmit logic and the transmit FIFO.
// The master modport drives push/pop/clear requests; the slave modport returns data, flags and errors.
interface ssp_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              psel;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              tx_pop;
  logic              clr_err;
  logic [DATA_W-1:0] txdata;
  logic              flag_empty;
  logic              flag_full;
  logic [ADDR_W:0]   level;
  logic              overrun;
  logic              underrun;

  modport master (
    output psel, pwrite, pwdata, tx_pop, clr_err,
    input  txdata, flag_empty, flag_full, level, overrun, underrun
  );

  modport slave (
    input  psel, pwrite, pwdata, tx_pop, clr_err,
    output txdata, flag_empty, flag_full, level, overrun, underrun
  );
endinterface

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: APB pushes, first-word-fall-through read to the serialiser; flags/level combinational from pointers.
// A pushed word is visible on txdata the cycle after its edge; dropped pushes and empty pops latch sticky errors.
module ssp_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input logic          pclk,
  input logic          clr_b,
  ssp_tx_fifo_if.slave bus
);
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [ADDR_W:0]   w_ptr_q, w_ptr_d;
  logic [ADDR_W:0]   r_ptr_q, r_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;

  logic              flag_empty;
  logic              flag_full;
  logic              push_req;
  logic              pop_ok;
  logic              push_ok;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;

  assign w_addr     = w_ptr_q[ADDR_W-1:0];
  assign r_addr     = r_ptr_q[ADDR_W-1:0];
  assign flag_empty = (w_ptr_q == r_ptr_q);
  // Same slot but opposite wrap phase means the writer is a full lap ahead.
  assign flag_full  = (w_addr == r_addr) && (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]);

  assign push_req = bus.psel && bus.pwrite;
  assign pop_ok   = bus.tx_pop && !flag_empty;
  // A pop on the same edge frees the slot the push needs when full.
  assign push_ok  = push_req && (!flag_full || pop_ok);

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    mem_d   = mem_q;
    if (pop_ok) begin
      r_ptr_d = r_ptr_q + PTR_ONE;
    end
    if (push_ok) begin
      mem_d[w_addr] = bus.pwdata;
      w_ptr_d       = w_ptr_q + PTR_ONE;
    end
    // A fresh error in the clearing cycle must not be lost.
    overrun_d  = (overrun_q && !bus.clr_err) || (push_req && !push_ok);
    underrun_d = (underrun_q && !bus.clr_err) || (bus.tx_pop && flag_empty);
  end

  always_ff @(posedge pclk or posedge clr_b) begin
    if (clr_b) begin
      w_ptr_q    <= '0;
      r_ptr_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      w_ptr_q    <= w_ptr_d;
      r_ptr_q    <= r_ptr_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      mem_q      <= mem_d;
    end
  end

  assign bus.txdata     = mem_q[r_addr];
  assign bus.flag_empty = flag_empty;
  assign bus.flag_full  = flag_full;
  assign bus.level      = w_ptr_q - r_ptr_q;
  assign bus.overrun    = overrun_q;
  assign bus.underrun   = underrun_q;
endmodule
